// File: rtl/cnt_unary_pkg.sv
// cnt_unary_pkg
//   Shared types and defaults for the unary (thermometer) expander that
//   regenerates a bit vector from a carry-save ones-count.
//   Contents:
//     DEPTH_DEF / WIDTH_DEF  default output length and count width
//     state_t                control states IDLE / LOAD / EMIT
//     thermo_f(n)            DEPTH_DEF-bit thermometer of n, saturating at all-ones
package cnt_unary_pkg;

  localparam int DEPTH_DEF = 12;
  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_t;

  // Bit i is set when n > i, so any n >= DEPTH_DEF yields all ones.
  function automatic logic [DEPTH_DEF-1:0] thermo_f(input logic [WIDTH_DEF-1:0] n);
    logic [DEPTH_DEF-1:0] t;
    t = '0;
    for (int i = 0; i < DEPTH_DEF; i++) begin
      t[i] = (n > WIDTH_DEF'(i));
    end
    return t;
  endfunction

endpackage

// File: rtl/thermo_enc.sv
// thermo_enc
//   Combinational count -> thermometer encoder. Output bit i is 1 when the
//   count exceeds i, so bits [n-1:0] are set. Counts of DEPTH or more
//   saturate to all ones.
//   Ports:
//     n       in   WIDTH  count to encode
//     thermo  out  DEPTH  thermometer word
module thermo_enc
  import cnt_unary_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] n,
  output logic [DEPTH-1:0] thermo
);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bit
      assign thermo[gi] = (n > WIDTH'(gi));
    end
  endgenerate

endmodule

// File: rtl/cnt_unary_ser.sv
// cnt_unary_ser
//   Expands a population count into a canonical bit vector with that many
//   ones: a registered thermometer word plus a DEPTH-beat serial stream.
//   Ports:
//     clk, rst_n      clock (rising edge), async active-low reset
//     cnt_valid/cnt_ready/cnt   count input handshake ({cy,sum})
//     thermo, thermo_valid      thermometer word and its one-cycle update pulse
//     ser_valid/ser_ready       serial beat handshake
//     ser_bit, ser_last         beat data (beat k = thermo[k]) and final-beat flag
//     err                       one-cycle pulse when the captured count was saturated
module cnt_unary_ser
  import cnt_unary_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_valid,
  output logic             cnt_ready,
  input  logic [WIDTH-1:0] cnt,
  output logic [DEPTH-1:0] thermo,
  output logic             thermo_valid,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_bit,
  output logic             ser_last,
  output logic             err
);

  localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);
  localparam logic [WIDTH-1:0] LAST_W  = WIDTH'(DEPTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] n_reg;
  logic [WIDTH-1:0] idx_reg;
  logic [DEPTH-1:0] thermo_reg;
  logic [DEPTH-1:0] thermo_enc_w;
  logic             thermo_valid_reg;
  logic             err_reg;
  logic             accept;
  logic             beat;
  logic             cnt_over;

  thermo_enc #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_enc (
    .n      (n_reg),
    .thermo (thermo_enc_w)
  );

  assign cnt_over = (cnt > DEPTH_W);
  assign accept   = cnt_valid && cnt_ready;
  assign beat     = ser_valid && ser_ready;

  // Beat outputs are qualified by EMIT so nothing leaks out while idle or
  // held in reset.
  assign ser_bit  = (state_reg == EMIT) && (idx_reg < n_reg);
  assign ser_last = (state_reg == EMIT) && (idx_reg == LAST_W);

  assign thermo       = thermo_reg;
  assign thermo_valid = thermo_valid_reg;
  assign err          = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_ready  = 1'b0;
    ser_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_ready = 1'b1;
        if (cnt_valid) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        state_next = EMIT;
      end
      EMIT: begin
        ser_valid = 1'b1;
        if (ser_ready && ser_last) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_reg            <= '0;
      idx_reg          <= '0;
      thermo_reg       <= '0;
      thermo_valid_reg <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      // err is registered with the capture so it is visible during LOAD
      // and drops on the next edge.
      err_reg          <= accept && cnt_over;
      thermo_valid_reg <= (state_reg == LOAD);
      if (accept) begin
        n_reg <= cnt_over ? DEPTH_W : cnt;
      end
      if (state_reg == LOAD) begin
        thermo_reg <= thermo_enc_w;
        idx_reg    <= '0;
      end else if (beat && !ser_last) begin
        idx_reg <= idx_reg + WIDTH'(1);
      end
    end
  end

endmodule
